// File: rtl/chacha_pkg.sv
// Shared encodings and widths for the ChaCha20 payload XOR stage.
package chacha_pkg;

  localparam int unsigned KS_W   = 512;
  localparam int unsigned BEAT_W = 128;
  localparam int unsigned KEEP_W = 16;
  localparam int unsigned LEN_W  = 64;
  localparam int unsigned LANES  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StKsReq,
    StKsWait,
    StRun,
    StLen
  } state_e;

endpackage

// File: rtl/keep_mask_popcnt.sv
// Expands a byte keep mask into a bit mask and counts the kept bytes.
module keep_mask_popcnt
  import chacha_pkg::*;
(
  input  logic [KEEP_W-1:0] keep,
  output logic [BEAT_W-1:0] mask,
  output logic [4:0]        cnt
);

  always_comb begin
    mask = '0;
    cnt  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      mask[8*i +: 8] = {8{keep[i]}};
      cnt            = cnt + 5'(keep[i]);
    end
  end

endmodule

// File: rtl/chacha_pld_xor_stream.sv
// XORs ChaCha20 keystream onto a 128-bit payload stream, feeds ciphertext to Poly1305
// and hands over the AAD/CT lengths block once the message is complete.
module chacha_pld_xor_stream
  import chacha_pkg::*;
#(
  parameter bit LEN_IN_BITS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic              pld_empty,
  input  logic [LEN_W-1:0]  aad_len_bytes,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              ks_req,
  input  logic              ks_valid,
  input  logic [KS_W-1:0]   ks_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              pld_valid,
  input  logic              pld_ready,
  output logic [BEAT_W-1:0] pld_data,
  output logic [KEEP_W-1:0] pld_keep,
  output logic              len_valid,
  input  logic              len_ready,
  output logic [127:0]      len_block,
  output logic              busy,
  output logic              done
);

  state_e                        state_q;
  logic [LANES-1:0][BEAT_W-1:0]  ks_q;
  logic [1:0]                    lane_q;
  logic [LEN_W-1:0]              byte_cnt_q;
  logic [LEN_W-1:0]              aad_q;
  logic                          decrypt_q;

  logic [BEAT_W-1:0] byte_mask;
  logic [4:0]        beat_bytes;
  logic [LEN_W-1:0]  cnt_next;
  logic [BEAT_W-1:0] xor_res;
  logic              accept;

  keep_mask_popcnt u_keep (
    .keep (in_keep),
    .mask (byte_mask),
    .cnt  (beat_bytes)
  );

  function automatic logic [LEN_W-1:0] len_field(input logic [LEN_W-1:0] c);
    return LEN_IN_BITS ? {c[LEN_W-4:0], 3'b000} : c;
  endfunction

  assign in_ready = (state_q == StRun) && (!out_valid || out_ready) && (!pld_valid || pld_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_next = byte_cnt_q + LEN_W'(beat_bytes);
  assign xor_res  = (in_data ^ ks_q[lane_q]) & byte_mask;
  assign ks_req   = (state_q == StKsReq);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ks_q       <= '0;
      lane_q     <= '0;
      byte_cnt_q <= '0;
      aad_q      <= '0;
      decrypt_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      pld_valid  <= 1'b0;
      pld_data   <= '0;
      pld_keep   <= '0;
      len_valid  <= 1'b0;
      len_block  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (pld_valid && pld_ready) pld_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            decrypt_q  <= decrypt;
            aad_q      <= aad_len_bytes;
            byte_cnt_q <= '0;
            if (pld_empty) begin
              len_block <= {len_field('0), len_field(aad_len_bytes)};
              state_q   <= StLen;
            end else begin
              state_q <= StKsReq;
            end
          end
        end
        StKsReq: state_q <= StKsWait;
        StKsWait: begin
          if (ks_valid) begin
            ks_q    <= ks_data;
            lane_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= xor_res;
            out_keep   <= in_keep;
            out_last   <= in_last;
            pld_valid  <= 1'b1;
            // Poly1305 always authenticates the ciphertext side of the stream.
            pld_data   <= decrypt_q ? (in_data & byte_mask) : xor_res;
            pld_keep   <= in_keep;
            byte_cnt_q <= cnt_next;
            lane_q     <= lane_q + 2'd1;
            if (in_last) begin
              len_block <= {len_field(cnt_next), len_field(aad_q)};
              state_q   <= StLen;
            end else if (lane_q == 2'd3) begin
              state_q <= StKsReq;
            end
          end
        end
        StLen: begin
          if (len_valid && len_ready) begin
            len_valid <= 1'b0;
            done      <= 1'b1;
            state_q   <= StIdle;
          end else if (!len_valid && !out_valid && !pld_valid) begin
            len_valid <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_pld_xor_stream.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_chacha_pld_xor_stream;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, decrypt = 1'b0, pld_empty = 1'b0;
  logic [63:0]  aad_len_bytes = '0;
  logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_keep = '0;
  logic         ks_req, ks_valid = 1'b0;
  logic [511:0] ks_data = '0;
  logic         out_valid, out_ready = 1'b1, out_last;
  logic [127:0] out_data, pld_data, len_block;
  logic [15:0]  out_keep, pld_keep;
  logic         pld_valid, pld_ready = 1'b1;
  logic         len_valid, len_ready = 1'b1;
  logic         busy, done;

  chacha_pld_xor_stream #(.LEN_IN_BITS(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .decrypt       (decrypt),
    .pld_empty     (pld_empty),
    .aad_len_bytes (aad_len_bytes),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_keep       (in_keep),
    .in_last       (in_last),
    .ks_req        (ks_req),
    .ks_valid      (ks_valid),
    .ks_data       (ks_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .pld_valid     (pld_valid),
    .pld_ready     (pld_ready),
    .pld_data      (pld_data),
    .pld_keep      (pld_keep),
    .len_valid     (len_valid),
    .len_ready     (len_ready),
    .len_block     (len_block),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  beat_t        exp_out[$];
  beat_t        exp_pld[$];
  logic [127:0] exp_len[$];
  logic [511:0] ks_blocks[$];
  logic [511:0] ks_default = '0;
  bit           ks_auto = 1'b1;
  int           ks_req_cnt = 0, beats_acc = 0, done_cnt = 0;
  int           beats_at_req[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) chk("out_unexpected", 128'd1, 128'd0);
          else begin
            b = exp_out.pop_front();
            chk("out_data", out_data, b.d);
            chk("out_keep_last", {out_keep, out_last}, {b.k, b.l});
          end
        end
        if (pld_valid && pld_ready) begin
          if (exp_pld.size() == 0) chk("pld_unexpected", 128'd1, 128'd0);
          else begin
            b = exp_pld.pop_front();
            chk("pld_data", pld_data, b.d);
            chk("pld_keep", pld_keep, b.k);
          end
        end
        if (len_valid && len_ready) begin
          if (exp_len.size() == 0) chk("len_unexpected", 128'd1, 128'd0);
          else chk("len_block", len_block, exp_len.pop_front());
        end
        if (ks_req) begin
          ks_req_cnt++;
          beats_at_req.push_back(beats_acc);
        end
        if (in_valid && in_ready) beats_acc++;
        if (done) done_cnt++;
      end
    end
  end

  // Keystream responder
  initial begin
    logic [511:0] blk;
    forever begin
      @(negedge clk);
      if (ks_req && ks_auto && !rst) begin
        blk = (ks_blocks.size() != 0) ? ks_blocks.pop_front() : ks_default;
        repeat (2) @(posedge clk);
        #1 ks_valid = 1'b1;
        ks_data = blk;
        @(posedge clk);
        #1 ks_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic begin_msg(input logic dec, input logic empty, input logic [63:0] aad);
    ks_req_cnt = 0;
    beats_acc  = 0;
    beats_at_req.delete();
    @(posedge clk);
    #1 start = 1'b1;
    decrypt = dec;
    pld_empty = empty;
    aad_len_bytes = aad;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l,
                      input logic [127:0] exp_o, input logic [127:0] exp_p);
    int n = 0;
    exp_out.push_back('{d: exp_o, k: k, l: l});
    exp_pld.push_back('{d: exp_p, k: k, l: 1'b0});
    in_data = d;
    in_keep = k;
    in_last = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("in_ready_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_msg(input string name, input int exp_ks);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 128'(done_cnt - d0), 128'd1);
    chk({name, "_ks_req"}, 128'(ks_req_cnt), 128'(exp_ks));
    chk({name, "_drained"}, 128'(exp_out.size() + exp_pld.size() + exp_len.size()), 128'd0);
    @(negedge clk);
    chk({name, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  task automatic run_t1(input string name);
    ks_default = {64{8'hA5}};
    exp_len.push_back({64'd128, 64'd160});
    begin_msg(1'b0, 1'b0, 64'd20);
    send('0, 16'hFFFF, 1'b1, {16{8'hA5}}, {16{8'hA5}});
    finish_msg(name, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {121'd0, busy, ks_req, in_ready, out_valid, pld_valid, len_valid, done},
        128'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single full beat, all-A5 keystream
    run_t1("t1");

    // Five beats over two keystream blocks, short last beat
    ks_blocks.push_back({{16{8'h13}}, {16{8'h12}}, {16{8'h11}}, {16{8'h10}}});
    ks_blocks.push_back({{16{8'h23}}, {16{8'h22}}, {16{8'h21}}, {16{8'h20}}});
    exp_len.push_back({64'd536, 64'd0});
    begin_msg(1'b0, 1'b0, 64'd0);
    send('0, 16'hFFFF, 1'b0, {16{8'h10}}, {16{8'h10}});
    send('0, 16'hFFFF, 1'b0, {16{8'h11}}, {16{8'h11}});
    send('0, 16'hFFFF, 1'b0, {16{8'h12}}, {16{8'h12}});
    send('0, 16'hFFFF, 1'b0, {16{8'h13}}, {16{8'h13}});
    send('0, 16'h0007, 1'b1, 128'h202020, 128'h202020);
    finish_msg("t2", 2);
    chk("t2_second_req_after_beat4", 128'(beats_at_req.size() == 2 ? beats_at_req[1] : -1),
        128'd4);

    // Decrypt: Poly sees the input beat
    ks_default = {64{8'hFF}};
    exp_len.push_back({64'd128, 64'd0});
    begin_msg(1'b1, 1'b0, 64'd0);
    send(128'h0123456789abcdef0123456789abcdef, 16'hFFFF, 1'b1,
         128'hfedcba9876543210fedcba9876543210, 128'h0123456789abcdef0123456789abcdef);
    finish_msg("t3", 1);

    // Poly backpressure stalls input without loss
    ks_default = {{16{8'h33}}, {16{8'h32}}, {16{8'h31}}, {16{8'h30}}};
    exp_len.push_back({64'd384, 64'd0});
    pld_ready = 1'b0;
    begin_msg(1'b0, 1'b0, 64'd0);
    fork
      begin
        repeat (10) @(posedge clk);
        #1 pld_ready = 1'b1;
      end
    join_none
    send({16{8'h01}}, 16'hFFFF, 1'b0, {16{8'h31}}, {16{8'h31}});
    @(negedge clk);
    chk("t4_in_ready_stalled", {127'd0, in_ready}, 128'd0);
    send({16{8'h02}}, 16'hFFFF, 1'b0, {16{8'h33}}, {16{8'h33}});
    send({16{8'h03}}, 16'hFFFF, 1'b1, {16{8'h31}}, {16{8'h31}});
    finish_msg("t4", 1);

    // Empty payload: lengths only, len_ready held off
    exp_len.push_back(128'h68);
    len_ready = 1'b0;
    begin_msg(1'b0, 1'b1, 64'd13);
    repeat (4) @(negedge clk);
    chk("t5_len_waiting", {126'd0, len_valid, done}, 128'b10);
    @(posedge clk);
    #1 len_ready = 1'b1;
    finish_msg("t5", 0);

    // Reset while waiting for keystream
    ks_auto = 1'b0;
    begin_msg(1'b0, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_after_reset", {121'd0, busy, ks_req, in_ready, out_valid, pld_valid, len_valid, done},
        128'd0);
    @(posedge clk);
    #1 ks_valid = 1'b1;
    ks_data = '1;
    @(posedge clk);
    #1 ks_valid = 1'b0;
    @(negedge clk);
    chk("t6_late_ks_ignored", {126'd0, busy, out_valid}, 128'd0);
    ks_auto = 1'b1;
    run_t1("t6_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
